// File: rtl/gs232c_circ_oldest_picker_if.sv
// Handshake bundle for gs232c_circ_oldest_picker.
//   N  : log2 of entry count (E = 1<<N), 0..5
//   CW : width of the stall statistics counter
// Names carry the picker's point of view: i_* flow into the picker, o_* flow out.
//   i_req[E]       per-entry request
//   i_head_inc     oldest entry retired, head advances by one
//   i_flush        drop the grant, head back to 0
//   i_out_ready    consumer accepts the grant this cycle
//   o_out_valid    grant present
//   o_out_idx      granted entry index (1 bit, tied 0, when N=0)
//   o_out_onehot   one-hot of o_out_idx, zero when no grant
//   o_head         current head pointer
//   o_stall_cnt    stalled-grant cycle count
// The picker binds to modport slave; the requester/consumer side binds to master.
interface gs232c_circ_oldest_picker_if #(
  parameter int N  = 3,
  parameter int CW = 16
);
  localparam int E  = 1 << N;
  localparam int IW = (N < 1) ? 1 : N;

  logic [E-1:0]  i_req;
  logic          i_head_inc;
  logic          i_flush;
  logic          i_out_ready;
  logic          o_out_valid;
  logic [IW-1:0] o_out_idx;
  logic [E-1:0]  o_out_onehot;
  logic [IW-1:0] o_head;
  logic [CW-1:0] o_stall_cnt;

  modport slave (
    input  i_req, i_head_inc, i_flush, i_out_ready,
    output o_out_valid, o_out_idx, o_out_onehot, o_head, o_stall_cnt
  );

  modport master (
    output i_req, i_head_inc, i_flush, i_out_ready,
    input  o_out_valid, o_out_idx, o_out_onehot, o_head, o_stall_cnt
  );
endinterface

// File: rtl/gs232c_circ_oldest_picker.sv
// Registered oldest-first picker for a circular queue of E = 1<<N entries.
// Grants the first requesting entry at or after the tracked head, in circular
// order, one cycle after the request. A grant is held until accepted.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  synchronous active-high reset
//   io_bus   gs232c_circ_oldest_picker_if.slave (request, head/flush control,
//            valid/ready grant output, head and stall statistics)
// Optional feature: define GS232C_PICKER_STATS_EN to build the saturating
// stall counter; otherwise o_stall_cnt is tied to 0 and no flops exist for it.
module gs232c_circ_oldest_picker #(
  parameter int N  = 3,
  parameter int CW = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  gs232c_circ_oldest_picker_if.slave    io_bus
);
  localparam int E  = 1 << N;
  localparam int IW = (N < 1) ? 1 : N;

  logic          r_valid;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_head;

  logic          w_fire;
  logic          w_free;
  logic [E-1:0]  w_onehot;
  logic [E-1:0]  w_req_e;
  logic          w_any;
  logic [IW-1:0] w_pick;

  always_comb begin
    w_fire   = r_valid & io_bus.i_out_ready;
    w_free   = ~r_valid | io_bus.i_out_ready;
    w_onehot = r_valid ? (E'(1) << r_idx) : '0;
    // The entry being accepted now must not be granted again from this
    // cycle's request vector (its req bit may not have dropped yet).
    w_req_e  = io_bus.i_req & ~(w_fire ? w_onehot : '0);
    w_any    = |w_req_e;
  end

  // Scan offsets from farthest to nearest so the entry closest to head
  // (at or after it, wrapping) is the last writer and wins.
  always_comb begin
    w_pick = '0;
    for (int k = E - 1; k >= 0; k--) begin
      if (w_req_e[r_head + IW'(k)]) w_pick = r_head + IW'(k);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_head  <= '0;
    end else if (io_bus.i_flush) begin
      r_valid <= 1'b0;
      r_head  <= '0;
    end else begin
      if (w_free) begin
        r_valid <= w_any;
        if (w_any) r_idx <= w_pick;
      end
      // Pick above used the old head; the advanced head applies next cycle.
      if (io_bus.i_head_inc && N > 0) r_head <= r_head + IW'(1);
    end
  end

`ifdef GS232C_PICKER_STATS_EN
  logic [CW-1:0] r_stall_cnt;

  // Counts every stalled-grant cycle, flush included; only reset clears it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !io_bus.i_out_ready && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  assign io_bus.o_stall_cnt = r_stall_cnt;
`else
  assign io_bus.o_stall_cnt = '0;
`endif

  assign io_bus.o_out_valid  = r_valid;
  assign io_bus.o_out_idx    = r_idx;
  assign io_bus.o_out_onehot = w_onehot;
  assign io_bus.o_head       = r_head;
endmodule

// File: tb/tb_gs232c_circ_oldest_picker.sv
// Self-checking bench: an N=3/CW=16 picker and an N=0/CW=2 picker share clock
// and reset; both are compared against a behavioural queue model.
module tb_gs232c_circ_oldest_picker;
`ifdef GS232C_PICKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gs232c_circ_oldest_picker_if #(.N(3), .CW(16)) if3 ();
  gs232c_circ_oldest_picker_if #(.N(0), .CW(2))  if0 ();

  gs232c_circ_oldest_picker #(.N(3), .CW(16)) dut3 (
    .i_clock(clk), .i_reset(rst), .io_bus(if3.slave));
  gs232c_circ_oldest_picker #(.N(0), .CW(2)) dut0 (
    .i_clock(clk), .i_reset(rst), .io_bus(if0.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m3_head, m3_idx, m3_stall;
  bit m3_valid;
  int m0_head, m0_idx, m0_stall;
  bit m0_valid;

  function automatic int pick(int rq, int h, int e);
    for (int k = 0; k < e; k++)
      if (rq[(h + k) % e]) return (h + k) % e;
    return -1;
  endfunction

  task automatic mstep(input int e, input int smax, input bit r, input bit f,
                       input bit hi, input bit rd, input int rq,
                       inout int hd, inout bit vl, inout int ix, inout int st);
    int rqe, p;
    if (r) begin
      hd = 0; vl = 0; ix = 0; st = 0;
    end else begin
      if (STATS && vl && !rd && st < smax) st = st + 1;
      if (f) begin
        hd = 0; vl = 0;
      end else begin
        rqe = rq;
        if (vl && rd) rqe = rqe & ~(1 << ix);
        if (!vl || rd) begin
          p = pick(rqe, hd, e);
          if (p >= 0) begin vl = 1; ix = p; end
          else vl = 0;
        end
        hd = (hd + (hi ? 1 : 0)) % e;
      end
    end
  endtask

  task automatic cyc();
    mstep(8, 65535, rst, if3.i_flush, if3.i_head_inc, if3.i_out_ready,
          int'(if3.i_req), m3_head, m3_valid, m3_idx, m3_stall);
    mstep(1, 3, rst, if0.i_flush, if0.i_head_inc, if0.i_out_ready,
          int'(if0.i_req), m0_head, m0_valid, m0_idx, m0_stall);
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    if3.i_req = '0; if3.i_head_inc = 0; if3.i_flush = 0; if3.i_out_ready = 0;
    if0.i_req = '0; if0.i_head_inc = 0; if0.i_flush = 0; if0.i_out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; cyc(); rst = 0;
  endtask

  function automatic logic [30:0] exp3();
    logic [7:0] oh;
    oh = m3_valid ? (8'd1 << m3_idx) : 8'd0;
    return {m3_valid, 3'(m3_idx), oh, 3'(m3_head), 16'(m3_stall)};
  endfunction

  function automatic logic [5:0] exp0();
    return {m0_valid, 1'(m0_idx), m0_valid, 1'(m0_head), 2'(m0_stall)};
  endfunction

  function automatic logic [30:0] act3();
    return {if3.o_out_valid, if3.o_out_idx, if3.o_out_onehot, if3.o_head, if3.o_stall_cnt};
  endfunction

  function automatic logic [5:0] act0();
    return {if0.o_out_valid, if0.o_out_idx, if0.o_out_onehot, if0.o_head, if0.o_stall_cnt};
  endfunction

  task automatic test_reset();
    if3.i_req = 8'hFF; if3.i_out_ready = 1; if0.i_req = 1'b1;
    rst = 1; cyc(); rst = 0;
    n_cmp++; if (act3() !== 31'd0) begin n_bad++; $display("FAIL reset_n3 got=%h want=0", act3()); end
    n_cmp++; if (act0() !== 6'd0) begin n_bad++; $display("FAIL reset_n0 got=%h want=0", act0()); end
    idle_inputs();
  endtask

  task automatic test_basic_pick();
    do_reset();
    if3.i_req = 8'hA0; if3.i_out_ready = 1; cyc();
    n_cmp++; if ({if3.o_out_valid, if3.o_out_idx, if3.o_out_onehot} !== {1'b1, 3'd5, 8'h20}) begin
      n_bad++; $display("FAIL basic_first got v=%b i=%0d oh=%h want v=1 i=5 oh=20",
                        if3.o_out_valid, if3.o_out_idx, if3.o_out_onehot); end
    cyc();
    n_cmp++; if (if3.o_out_idx !== 3'd7) begin n_bad++; $display("FAIL basic_second got=%0d want=7", if3.o_out_idx); end
    n_cmp++; if (act3() !== exp3()) begin n_bad++; $display("FAIL basic_model got=%h want=%h", act3(), exp3()); end
    idle_inputs();
  endtask

  task automatic test_head_wrap();
    do_reset();
    if3.i_head_inc = 1;
    repeat (6) cyc();
    if3.i_head_inc = 0;
    n_cmp++; if (if3.o_head !== 3'd6) begin n_bad++; $display("FAIL wrap_head6 got=%0d want=6", if3.o_head); end
    if3.i_req = 8'h43; if3.i_out_ready = 1; cyc();
    n_cmp++; if (if3.o_out_idx !== 3'd6 || if3.o_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL wrap_pick6 got v=%b i=%0d want v=1 i=6", if3.o_out_valid, if3.o_out_idx); end
    if3.i_req = '0; if3.i_head_inc = 1;
    repeat (2) cyc();
    if3.i_head_inc = 0;
    n_cmp++; if (if3.o_head !== 3'd0) begin n_bad++; $display("FAIL wrap_head0 got=%0d want=0", if3.o_head); end
    if3.i_req = 8'h82; cyc();
    n_cmp++; if (if3.o_out_idx !== 3'd1 || if3.o_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL wrap_pick1 got v=%b i=%0d want v=1 i=1", if3.o_out_valid, if3.o_out_idx); end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    if3.i_head_inc = 1; repeat (2) cyc(); if3.i_head_inc = 0;
    if3.i_req = 8'h0C; if3.i_out_ready = 0; cyc();
    n_cmp++; if (if3.o_out_idx !== 3'd2 || if3.o_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_grant got v=%b i=%0d want v=1 i=2", if3.o_out_valid, if3.o_out_idx); end
    repeat (2) cyc();
    if3.i_req = 8'h08;
    repeat (2) cyc();
    n_cmp++; if (if3.o_out_idx !== 3'd2 || if3.o_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_hold got v=%b i=%0d want v=1 i=2", if3.o_out_valid, if3.o_out_idx); end
    n_cmp++; if (if3.o_stall_cnt !== (STATS ? 16'd4 : 16'd0)) begin
      n_bad++; $display("FAIL stall_cnt got=%0d want=%0d", if3.o_stall_cnt, STATS ? 4 : 0); end
    if3.i_out_ready = 1; cyc();
    n_cmp++; if (if3.o_out_idx !== 3'd3 || if3.o_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_release got v=%b i=%0d want v=1 i=3", if3.o_out_valid, if3.o_out_idx); end
    n_cmp++; if (act3() !== exp3()) begin n_bad++; $display("FAIL stall_model got=%h want=%h", act3(), exp3()); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    if3.i_head_inc = 1; repeat (3) cyc(); if3.i_head_inc = 0;
    if3.i_req = 8'h10; if3.i_out_ready = 1; cyc();
    n_cmp++; if (if3.o_out_idx !== 3'd4 || if3.o_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL flush_pre got v=%b i=%0d want v=1 i=4", if3.o_out_valid, if3.o_out_idx); end
    if3.i_req = 8'hFF; if3.i_flush = 1; cyc();
    if3.i_flush = 0;
    n_cmp++; if (if3.o_out_valid !== 1'b0 || if3.o_head !== 3'd0) begin
      n_bad++; $display("FAIL flush_clear got v=%b h=%0d want v=0 h=0", if3.o_out_valid, if3.o_head); end
    cyc();
    n_cmp++; if (if3.o_out_idx !== 3'd0 || if3.o_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL flush_next got v=%b i=%0d want v=1 i=0", if3.o_out_valid, if3.o_out_idx); end
    idle_inputs();
  endtask

  task automatic test_n0();
    bit want_v[3] = '{1'b1, 1'b0, 1'b0};
    bit req_seq[3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    if0.i_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      if0.i_req = req_seq[i]; cyc();
      n_cmp++; if ({if0.o_out_valid, if0.o_out_idx, if0.o_head} !== {want_v[i], 1'b0, 1'b0}) begin
        n_bad++; $display("FAIL n0_seq%0d got v=%b i=%0d h=%0d want v=%b i=0 h=0",
                          i, if0.o_out_valid, if0.o_out_idx, if0.o_head, want_v[i]); end
    end
    if0.i_req = 1'b1; if0.i_out_ready = 0; cyc();
    repeat (5) cyc();
    n_cmp++; if (if0.o_stall_cnt !== (STATS ? 2'd3 : 2'd0)) begin
      n_bad++; $display("FAIL n0_sat got=%0d want=%0d", if0.o_stall_cnt, STATS ? 3 : 0); end
    n_cmp++; if (act0() !== exp0()) begin n_bad++; $display("FAIL n0_model got=%h want=%h", act0(), exp0()); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    if3.i_head_inc = 1; repeat (5) cyc(); if3.i_head_inc = 0;
    if3.i_req = 8'h01; cyc(); cyc();
    n_cmp++; if (if3.o_out_valid !== 1'b1 || if3.o_head !== 3'd5) begin
      n_bad++; $display("FAIL rstmid_pre got v=%b h=%0d want v=1 h=5", if3.o_out_valid, if3.o_head); end
    if3.i_req = 8'hFF; if3.i_out_ready = 1; rst = 1; cyc();
    n_cmp++; if (act3() !== 31'd0) begin n_bad++; $display("FAIL rstmid_clear got=%h want=0", act3()); end
    cyc();
    n_cmp++; if (if3.o_out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_nogrant got=%b want=0", if3.o_out_valid); end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if3.i_req       = 8'($urandom);
      if3.i_head_inc  = ($urandom_range(0, 3) == 0);
      if3.i_flush     = ($urandom_range(0, 19) == 0);
      if3.i_out_ready = ($urandom_range(0, 4) < 3);
      if0.i_req       = 1'($urandom);
      if0.i_head_inc  = 1'($urandom);
      if0.i_flush     = ($urandom_range(0, 19) == 0);
      if0.i_out_ready = 1'($urandom);
      rst             = ($urandom_range(0, 99) == 0);
      cyc();
      n_cmp++; if (act3() !== exp3()) begin n_bad++; $display("FAIL rand_n3 cyc=%0d got=%h want=%h", i, act3(), exp3()); end
      n_cmp++; if (act0() !== exp0()) begin n_bad++; $display("FAIL rand_n0 cyc=%0d got=%h want=%h", i, act0(), exp0()); end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m3_head = 0; m3_idx = 0; m3_stall = 0; m3_valid = 0;
    m0_head = 0; m0_idx = 0; m0_stall = 0; m0_valid = 0;
    @(negedge clk);
    test_reset();
    test_basic_pick();
    test_head_wrap();
    test_stall();
    test_flush();
    test_n0();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
